// File: rtl/orv64_itb_ctrl.sv
// Capture controller for the orv64 instruction trace buffer.
// It filters retired instructions by mode and trigger and writes them into the RAM's normal port.
module orv64_itb_ctrl #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_en,
  input  logic              cfg_mode,
  input  logic              cfg_trig_en,
  input  logic [DATA_W-1:0] cfg_trig_pc,
  input  logic [CNT_W-1:0]  cfg_post_cnt,
  input  logic              cfg_clr,
  input  logic              dbg_active,
  input  logic              retire_valid,
  input  logic [DATA_W-1:0] retire_pc,
  input  logic              retire_taken,
  output logic              itb_en,
  output logic [DATA_W-1:0] itb_data,
  output logic [ADDR_W-1:0] itb_addr,
  output logic [ADDR_W-1:0] itb_wptr,
  output logic              itb_wrapped,
  output logic              itb_triggered,
  output logic              itb_frozen,
  output logic [CNT_W-1:0]  itb_drop_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_POST   = 2'd2,
    ST_FROZEN = 2'd3
  } state_e;

  state_e           state, state_nxt;
  logic [CNT_W-1:0] post_cnt, post_cnt_nxt;
  logic             disc;
  logic             capturing, qual, hit, wr, drop;

  assign capturing = (state == ST_RUN) || (state == ST_POST);
  assign qual      = retire_valid && capturing && (!cfg_mode || retire_taken);
  assign hit       = qual && cfg_trig_en && (retire_pc == cfg_trig_pc);
  assign wr        = qual && !dbg_active;
  assign drop      = qual && dbg_active;

  // NOTE: every output of a combinational block gets a default first; otherwise an
  // unassigned path infers a latch.
  always_comb begin
    state_nxt    = state;
    post_cnt_nxt = post_cnt;
    if (cfg_clr) begin
      state_nxt    = ST_IDLE;
      post_cnt_nxt = '0;
    end else begin
      unique case (state)
        ST_IDLE: if (cfg_en) state_nxt = ST_RUN;
        ST_RUN: begin
          if (hit) begin
            if (cfg_post_cnt == '0) begin
              state_nxt = ST_FROZEN;
            end else begin
              state_nxt    = ST_POST;
              post_cnt_nxt = cfg_post_cnt;
            end
          end else if (!cfg_en) begin
            state_nxt = ST_IDLE;
          end
        end
        ST_POST: begin
          // Only real writes count down; dropped entries leave the counter alone.
          if (wr) post_cnt_nxt = post_cnt - 1'b1;
          if (wr && post_cnt == CNT_W'(1)) state_nxt = ST_FROZEN;
          else if (!cfg_en)                state_nxt = ST_IDLE;
        end
        ST_FROZEN: state_nxt = ST_FROZEN;
        default:   state_nxt = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ST_IDLE;
      post_cnt      <= '0;
      disc          <= 1'b1;
      itb_en        <= 1'b0;
      itb_data      <= '0;
      itb_addr      <= '0;
      itb_wptr      <= '0;
      itb_wrapped   <= 1'b0;
      itb_triggered <= 1'b0;
      itb_frozen    <= 1'b0;
      itb_drop_cnt  <= '0;
    end else begin
      state      <= state_nxt;
      post_cnt   <= post_cnt_nxt;
      itb_frozen <= (state_nxt == ST_FROZEN);
      if (cfg_clr) begin
        // Clear wins over any same-cycle retire; data/addr keep their last values.
        disc          <= 1'b1;
        itb_en        <= 1'b0;
        itb_wptr      <= '0;
        itb_wrapped   <= 1'b0;
        itb_triggered <= 1'b0;
        itb_drop_cnt  <= '0;
      end else begin
        itb_en <= wr;
        if (hit) itb_triggered <= 1'b1;
        if (wr) begin
          itb_data <= {retire_pc[DATA_W-1:1], disc};
          itb_addr <= itb_wptr;
          itb_wptr <= itb_wptr + 1'b1;
          disc     <= 1'b0;
          if (itb_wptr == '1) itb_wrapped <= 1'b1;
        end else if (drop) begin
          disc <= 1'b1;
          if (itb_drop_cnt != '1) itb_drop_cnt <= itb_drop_cnt + 1'b1;
        end else if (state == ST_IDLE && cfg_en) begin
          disc <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/orv64_itb_ctrl.md
Name: orv64_itb_ctrl

Overview:
- Capture controller directly upstream of the instruction trace buffer RAM.
- Samples retired-instruction events from the orv64 commit stage, filters them by mode and trigger, and packs them into RAM entries.
- Drives the RAM's write-only normal port (en/data/addr) with a wrapping write pointer; exposes status and debug pointer readback.
- Debug-side RAM reads and writes use the RAM's own debug port and are outside this block; this block only suspends capture while debug is active.

Parameters:
- DATA_W, 64, RAM entry width; must match the RAM data width.
- ADDR_W, 8, RAM address width; depth = 2**ADDR_W.
- CNT_W, 16, width of the post-trigger counter and the drop counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- cfg_en  in  1  trace enable
- cfg_mode  in  1  0 = record every retire; 1 = record only taken control-flow retires
- cfg_trig_en  in  1  enable PC-match trigger
- cfg_trig_pc  in  DATA_W  trigger PC
- cfg_post_cnt  in  CNT_W  entries to record after trigger before freezing
- cfg_clr  in  1  one-cycle pulse: clear pointer, flags, counters; return to IDLE
- dbg_active  in  1  debug owns the RAM; suppress captures
- retire_valid  in  1  instruction retired this cycle
- retire_pc  in  DATA_W  PC of retired instruction (bit0 always 0)
- retire_taken  in  1  retired instruction redirected flow
- itb_en  out  1  RAM write strobe
- itb_data  out  DATA_W  RAM write data
- itb_addr  out  ADDR_W  RAM write address
- itb_wptr  out  ADDR_W  next write address
- itb_wrapped  out  1  pointer has wrapped at least once (buffer full)
- itb_triggered  out  1  trigger hit since last clear
- itb_frozen  out  1  capture stopped (FROZEN state)
- itb_drop_cnt  out  CNT_W  qualifying retires lost to dbg_active, saturating

Behaviour:
- Reset (rst low, async): all outputs 0, state IDLE, discontinuity flag set, post counter 0.
- States and transitions:
  - IDLE: cfg_en=1 -> RUN.
  - RUN: trigger hit with cfg_post_cnt=0 -> FROZEN; trigger hit otherwise -> POST, load post counter with cfg_post_cnt; cfg_en=0 -> IDLE.
  - POST: each written entry decrements the counter; a write that takes it to 0 -> FROZEN after that write. cfg_en=0 -> IDLE, keeping itb_triggered.
  - FROZEN: hold until cfg_clr; cfg_en is ignored.
  - cfg_clr from any state -> IDLE, clearing wptr, wrapped, triggered, drop count and post counter, and setting the discontinuity flag. Same-cycle retire is discarded. cfg_clr has priority over all other events.
- Qualifying retire: retire_valid & state in {RUN, POST} & (cfg_mode=0 | retire_taken).
- Trigger hit: a qualifying retire with cfg_trig_en & retire_pc == cfg_trig_pc; the triggering entry is itself written. itb_triggered sets the cycle after the hit.
- Write: qualifying & ~dbg_active.
  - Next cycle: itb_en=1, itb_addr = wptr, itb_data = {retire_pc[DATA_W-1:1], disc}.
  - Write latency is exactly 1 cycle; at most one write per cycle; there is no back-pressure.
  - itb_en=0 on all other cycles; itb_data/itb_addr hold their last values.
- Write pointer:
  - wptr increments modulo 2**ADDR_W on each write.
  - At wrap from all-ones to 0, itb_wrapped sets sticky; there is no stall and the oldest entry is overwritten.
- Discontinuity (disc) flag:
  - Set on reset, cfg_clr, entry into RUN from IDLE, and any drop.
  - Cleared by a write; the written entry carries disc=1.
- Drop: qualifying & dbg_active. itb_drop_cnt increments, saturating at all-ones; nothing is written; the post counter is not decremented. A trigger hit during a drop is still recognised.
- itb_frozen = (state == FROZEN), registered.
- Status outputs update the cycle after the causing event.

Test Plan:
- Reset, cfg_en=1, mode 0, 3 retires at PC 0x1000/0x1004/0x1008 -> itb_en pulses one cycle later at addr 0,1,2; data bit0 = 1,0,0; itb_wptr=3.
- Mode 1, 4 retires with retire_taken=0,1,0,1 -> exactly 2 writes, addr 0 and 1.
- ADDR_W=3, 9 back-to-back retires -> 9th write at addr 0; itb_wrapped rises the cycle after the 8th write; itb_wptr=1.
- cfg_trig_pc=0x2000, cfg_post_cnt=2; retires 0x1ff0, 0x2000, 0x2004, 0x2008, 0x200c -> 4 writes (0x1ff0, 0x2000, 0x2004, 0x2008); itb_frozen=1 after 0x2008; 0x200c not written.
- dbg_active=1 during 3 qualifying retires, then 1 retire with dbg_active=0 -> drop_cnt=3, one write with bit0=1; drop_cnt=all-ones stays saturated on a further drop.
- cfg_clr coincident with a retire while in POST -> no write; wptr=0; all flags 0; state IDLE (RUN next cycle if cfg_en=1). Async rst low mid-stream -> all outputs 0 immediately.
